// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed program image on a UART RX line, packs
// the payload into 32-bit little-endian words, writes them to instruction
// memory from ADDR_PROGRAM_MIN upward, and holds the core in reset meanwhile.
// Frame: 0xA5, LEN_HI, LEN_LO, 4*LEN payload bytes, CHK (XOR of payload).
// Optional: define LOADER_TIMEOUT_EN to abort a frame that stalls for
// TIMEOUT_BITS bit-times between bytes (err_code 100).
module uart_boot_loader #(
  parameter int unsigned CLK_FREQ         = 50_000_000,
  parameter int unsigned BAUD             = 9600,
  parameter logic [31:0] ADDR_PROGRAM_MIN = 32'h0040_0000,
  parameter int unsigned MAX_WORDS        = 64,
  parameter int unsigned TIMEOUT_BITS     = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        cpu_hold,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err_code,
  output logic [15:0] word_count
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [2:0] ERR_NONE     = 3'b000;
  localparam logic [2:0] ERR_FRAMING  = 3'b001;
  localparam logic [2:0] ERR_LENGTH   = 3'b010;
  localparam logic [2:0] ERR_CHECKSUM = 3'b011;
  localparam logic [2:0] ERR_TIMEOUT  = 3'b100;

  // A bit time below two clocks cannot be mid-sampled; refuse to elaborate.
  if (CLKS_PER_BIT < 2 || TIMEOUT_BITS == 0) begin : g_bad_cfg
    $error("uart_boot_loader: CLKS_PER_BIT must be >= 2 and TIMEOUT_BITS nonzero");
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {L_IDLE, L_LEN_HI, L_LEN_LO, L_DATA, L_CHECK, L_DONE} ld_state_e;

  // ---------------- byte receiver ----------------
  logic            rx_meta_q, rx_sync_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            frame_err_q, frame_err_d;

  // Two-flop synchronizer for the asynchronous RX line (idles high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver next state: mid-bit sampling of start, 8 data bits LSB first, stop.
  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    rx_byte_d    = rx_byte_q;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        bit_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
        else            rx_state_d = RX_IDLE;
      end
      RX_START: begin
        if (bit_cnt_q == CW'(HALF_BIT - 1)) begin
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          if (rx_sync_q) rx_state_d = RX_IDLE;   // glitch, not a start bit
          else           rx_state_d = RX_DATA;
        end else begin
          rx_state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_idx_d  = bit_idx_q + 3'd1;
        end else begin
          rx_state_d = RX_DATA;
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            rx_byte_d    = shift_q;
          end else begin
            frame_err_d  = 1'b1;
          end
        end else begin
          rx_state_d = RX_STOP;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver state and byte/error pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_valid_q <= 1'b0;
      rx_byte_q    <= 8'h00;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      rx_byte_q    <= rx_byte_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ---------------- loader ----------------
  ld_state_e   state_q, state_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  chk_q, chk_d;
  logic [1:0]  lane_q, lane_d;
  logic [23:0] word_buf_q, word_buf_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  err_q, err_d;
  logic [15:0] word_count_q, word_count_d;
  logic [15:0] len_new_s;
  logic        tmo_hit_s;

  assign len_new_s = {len_hi_q, rx_byte_q};

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TW        = $clog2(TMO_LIMIT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Inter-byte stall counter, live only while a frame is open.
  always_comb begin
    if ((state_q == L_LEN_HI || state_q == L_LEN_LO || state_q == L_DATA ||
         state_q == L_CHECK) && !byte_valid_q) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = '0;
    end
  end

  assign tmo_hit_s = (tmo_q == TW'(TMO_LIMIT - 1));

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Loader next state: frame parsing, word assembly, write strobe, status.
  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    len_d        = len_q;
    chk_d        = chk_q;
    lane_d       = lane_q;
    word_buf_d   = word_buf_q;
    cpu_hold_d   = cpu_hold_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    done_d       = done_q;
    err_d        = err_q;
    word_count_d = word_count_q;
    if (frame_err_q) begin
      err_d   = ERR_FRAMING;
      state_d = L_IDLE;
    end else if (mem_we_q) begin
      // Strobe cycle: the address was valid during the write, advance now.
      mem_addr_d   = mem_addr_q + 32'd4;
      word_count_d = word_count_q + 16'd1;
      if (word_count_q + 16'd1 == len_q) state_d = L_CHECK;
      else                               state_d = state_q;
    end else if (state_q == L_DONE) begin
      done_d     = 1'b1;
      cpu_hold_d = 1'b0;
      state_d    = L_IDLE;
    end else if (tmo_hit_s) begin
      err_d   = ERR_TIMEOUT;
      state_d = L_IDLE;
    end else if (byte_valid_q) begin
      case (state_q)
        L_IDLE: begin
          if (rx_byte_q == 8'hA5) begin
            state_d      = L_LEN_HI;
            cpu_hold_d   = 1'b1;
            done_d       = 1'b0;
            err_d        = ERR_NONE;
            word_count_d = 16'd0;
            chk_d        = 8'h00;
            lane_d       = 2'd0;
            mem_addr_d   = ADDR_PROGRAM_MIN;
          end else begin
            state_d = L_IDLE;
          end
        end
        L_LEN_HI: begin
          len_hi_d = rx_byte_q;
          state_d  = L_LEN_LO;
        end
        L_LEN_LO: begin
          len_d = len_new_s;
          if (len_new_s > 16'(MAX_WORDS)) begin
            err_d   = ERR_LENGTH;
            state_d = L_IDLE;
          end else if (len_new_s == 16'd0) begin
            state_d = L_CHECK;
          end else begin
            state_d = L_DATA;
          end
        end
        L_DATA: begin
          chk_d  = chk_q ^ rx_byte_q;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: word_buf_d[7:0]   = rx_byte_q;
            2'd1: word_buf_d[15:8]  = rx_byte_q;
            2'd2: word_buf_d[23:16] = rx_byte_q;
            2'd3: begin
              mem_wdata_d = {rx_byte_q, word_buf_q};
              mem_we_d    = 1'b1;
            end
            default: word_buf_d = word_buf_q;
          endcase
        end
        L_CHECK: begin
          if (rx_byte_q == chk_q) begin
            state_d = L_DONE;
          end else begin
            err_d   = ERR_CHECKSUM;
            state_d = L_IDLE;
          end
        end
        default: state_d = L_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != L_IDLE);
  end

  // Loader state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= L_IDLE;
      len_hi_q     <= 8'h00;
      len_q        <= 16'd0;
      chk_q        <= 8'h00;
      lane_q       <= 2'd0;
      word_buf_q   <= 24'd0;
      cpu_hold_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= ADDR_PROGRAM_MIN;
      mem_wdata_q  <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= ERR_NONE;
      word_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      chk_q        <= chk_d;
      lane_q       <= lane_d;
      word_buf_q   <= word_buf_d;
      cpu_hold_q   <= cpu_hold_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
    end
  end

  assign cpu_hold   = cpu_hold_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_code   = err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: serial frames (directed and random) are built
// from the frame format; expected writes and status come from that format.
module tb_uart_boot_loader;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int          CPB      = 16;
  localparam logic [31:0] BASE     = 32'h0040_0000;

  logic        clk;
  logic        rst;
  logic        rx;
  logic        cpu_hold, mem_we, busy, done;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  err_code;
  logic [15:0] word_count;

  int          checks;
  int          failures;
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  txq[$];
  logic [7:0]  run_chk;
  logic        we_prev   = 1'b0;
  logic        we_double = 1'b0;

  uart_boot_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .cpu_hold(cpu_hold), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err_code(err_code), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every write strobe and flag any strobe longer than one cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
    end
    if (mem_we === 1'b1 && we_prev === 1'b1) we_double <= 1'b1;
    we_prev <= mem_we;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = good_stop;
    repeat (good_stop ? CPB : 12) @(negedge clk);
    rx = 1'b1;
    repeat (good_stop ? $urandom_range(0, 8) : 2 * CPB) @(negedge clk);
  endtask

  task automatic send_all();
    foreach (txq[i]) send_byte(txq[i], 1'b1);
    txq.delete();
  endtask

  task automatic push_header(input logic [15:0] len);
    txq.push_back(8'hA5);
    txq.push_back(len[15:8]);
    txq.push_back(len[7:0]);
    run_chk = 8'h00;
  endtask

  // One payload word: four little-endian bytes plus the write it should cause.
  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      txq.push_back(w[8*k +: 8]);
      run_chk = run_chk ^ w[8*k +: 8];
    end
    exp_addr.push_back(BASE + 32'(exp_addr.size()) * 32'd4);
    exp_data.push_back(w);
  endtask

  task automatic check_reset(input string name);
    check_eq({name, ".hold"}, 32'(cpu_hold), 32'd0);
    check_eq({name, ".we"}, 32'(mem_we), 32'd0);
    check_eq({name, ".addr"}, mem_addr, BASE);
    check_eq({name, ".wdata"}, mem_wdata, 32'd0);
    check_eq({name, ".busy"}, 32'(busy), 32'd0);
    check_eq({name, ".done"}, 32'(done), 32'd0);
    check_eq({name, ".err"}, 32'(err_code), 32'd0);
    check_eq({name, ".wc"}, 32'(word_count), 32'd0);
  endtask

  task automatic check_frame(input string name, input logic exp_done, input logic [2:0] exp_err,
                             input logic exp_hold, input logic [15:0] exp_wc);
    repeat (24) @(negedge clk);
    check_eq({name, ".done"}, 32'(done), 32'(exp_done));
    check_eq({name, ".err"}, 32'(err_code), 32'(exp_err));
    check_eq({name, ".hold"}, 32'(cpu_hold), 32'(exp_hold));
    check_eq({name, ".wc"}, 32'(word_count), 32'(exp_wc));
    check_eq({name, ".busy"}, 32'(busy), 32'd0);
    check_eq({name, ".we_width"}, 32'(we_double), 32'd0);
    check_eq({name, ".nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check_eq({name, ".waddr"}, got_addr[i], exp_addr[i]);
      check_eq({name, ".wdata"}, got_data[i], exp_data[i]);
    end
    got_addr.delete();
    got_data.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  initial begin
    int          kind;
    logic [15:0] len;
    bit          badchk;
    logic [7:0]  flip;

    checks   = 0;
    failures = 0;
    run_chk  = 8'h00;
    rst      = 1'b0;
    rx       = 1'b1;
    repeat (4) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Two-word image; hold must rise as soon as the sync byte lands.
    send_byte(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("t1.hold_after_sync", 32'(cpu_hold), 32'd1);
    check_eq("t1.busy_after_sync", 32'(busy), 32'd1);
    txq.push_back(8'h00);
    txq.push_back(8'h02);
    exp_addr.push_back(BASE);          exp_data.push_back(32'h0000_0013);
    exp_addr.push_back(BASE + 32'd4);  exp_data.push_back(32'h0010_0093);
    txq.push_back(8'h13); txq.push_back(8'h00); txq.push_back(8'h00); txq.push_back(8'h00);
    txq.push_back(8'h93); txq.push_back(8'h00); txq.push_back(8'h10); txq.push_back(8'h00);
    txq.push_back(8'h90);
    send_all();
    check_frame("t1", 1'b1, 3'b000, 1'b0, 16'd2);

    // Bad checksum: the word is still written, hold stays asserted.
    push_header(16'd1);
    push_word(32'h4433_2211);
    txq.push_back(8'h00);
    send_all();
    check_frame("t2", 1'b0, 3'b011, 1'b1, 16'd1);
    push_header(16'd2);
    push_word(32'h0000_0013);
    push_word(32'h0010_0093);
    txq.push_back(8'h90);
    send_all();
    check_frame("t2b", 1'b1, 3'b000, 1'b0, 16'd2);

    // Length one above the limit.
    push_header(16'd65);
    send_all();
    check_frame("t3", 1'b0, 3'b010, 1'b1, 16'd0);

    // Sync byte with a low stop bit: framing error, frame not opened.
    send_byte(8'hA5, 1'b0);
    check_frame("t4a", 1'b0, 3'b001, 1'b1, 16'd0);

    // Short low glitches between header bytes must not be taken as bytes.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int g = 0; g < 3; g++) begin
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
    txq.push_back(8'h01);
    run_chk = 8'h00;
    push_word(32'h4433_2211);
    txq.push_back(run_chk);
    send_all();
    check_frame("t4b", 1'b1, 3'b000, 1'b0, 16'd1);

    // Junk before the sync byte, then an empty image.
    txq.push_back(8'h55); txq.push_back(8'h00);
    txq.push_back(8'hA5); txq.push_back(8'h00); txq.push_back(8'h00); txq.push_back(8'h00);
    send_all();
    check_frame("t5", 1'b1, 3'b000, 1'b0, 16'd0);

    // Reset in the middle of the payload.
    push_header(16'd2);
    txq.push_back(8'h11);
    txq.push_back(8'h22);
    send_all();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset("t6");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    txq.push_back(8'h33);
    txq.push_back(8'h44);
    send_all();
    check_frame("t6b", 1'b0, 3'b000, 1'b0, 16'd0);
    check_eq("t6b.addr", mem_addr, BASE);

    // Random frames: valid, corrupted checksum, or oversize length.
    for (int f = 0; f < 10; f++) begin
      kind   = $urandom_range(0, 9);
      badchk = (kind >= 8);
      if (kind == 0) len = 16'($urandom_range(65, 400));
      else           len = 16'($urandom_range(0, 4));
      push_header(len);
      if (len > 16'd64) begin
        send_all();
        check_frame("rnd_len", 1'b0, 3'b010, 1'b1, 16'd0);
      end else begin
        for (int w = 0; w < int'(len); w++) push_word($urandom);
        flip = 8'h01 << $urandom_range(0, 7);
        txq.push_back(badchk ? (run_chk ^ flip) : run_chk);
        send_all();
        if (badchk) check_frame("rnd_bad", 1'b0, 3'b011, 1'b1, len);
        else        check_frame("rnd_ok", 1'b1, 3'b000, 1'b0, len);
      end
    end

`ifdef LOADER_TIMEOUT_EN
    // Stall after the sync byte until the inter-byte timeout fires.
    send_byte(8'hA5, 1'b1);
    repeat (700) @(negedge clk);
    check_frame("tmo", 1'b0, 3'b100, 1'b1, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
